// File: rtl/ball_motion_generator.sv
// ball_motion_generator
//   Produces the ball position from the direction code and the stand flag
//   supplied by the direction-change logic. The ball moves one pixel
//   horizontally per motion tick. Vertical motion is full-rate, half-rate
//   or zero, depending on the direction code. Single-pixel steps ensure that
//   the equality-based border and paddle checks downstream never miss a
//   crossing.
//
// Ports
//   clk                    system clock, rising edge
//   reset_to_start         synchronous active-high reset to the start point
//   stand                  freeze request (sticky until reset)
//   direction[3:0]         motion code 1..10, any other value holds position
//   ball_coord_horizontal  ball X (registered)
//   ball_coord_vertical    ball Y (registered)
//   move_tick              one-cycle pulse in the cycle the coordinates update
//   ball_active            high while in MOVING
//
// Handshake: there is no valid/ready pair. move_tick marks each cycle in
// which the coordinate outputs hold a freshly updated value.
module ball_motion_generator #(
  parameter int MOVE_DIV    = 250000,
  parameter int SERVE_TICKS = 50,
  parameter int START_H     = 462,
  parameter int START_V     = 302,
  parameter int H_MIN       = 225,
  parameter int H_MAX       = 700,
  parameter int V_MIN       = 165,
  parameter int V_MAX       = 440
) (
  input  logic        clk,
  input  logic        reset_to_start,
  input  logic        stand,
  input  logic [3:0]  direction,
  output logic [15:0] ball_coord_horizontal,
  output logic [15:0] ball_coord_vertical,
  output logic        move_tick,
  output logic        ball_active
);

  localparam int DIV_W   = $clog2(MOVE_DIV);
  localparam int SERVE_W = $clog2(SERVE_TICKS + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(MOVE_DIV - 1);
  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_TICKS - 1);
  localparam logic [15:0] START_H_C = 16'(START_H);
  localparam logic [15:0] START_V_C = 16'(START_V);
  localparam logic [15:0] H_MIN_C   = 16'(H_MIN);
  localparam logic [15:0] H_MAX_C   = 16'(H_MAX);
  localparam logic [15:0] V_MIN_C   = 16'(V_MIN);
  localparam logic [15:0] V_MAX_C   = 16'(V_MAX);

  typedef enum logic [1:0] {
    SERVE   = 2'd0,
    MOVING  = 2'd1,
    STOPPED = 2'd2
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [SERVE_W-1:0] serve_cnt;
  logic               phase;
  logic               tick;

  logic        dir_valid;
  logic        dx_pos;
  logic        v_up;
  logic        v_down;
  logic        v_full;
  logic        v_step;
  logic [15:0] x_cand;
  logic [15:0] y_cand;
  logic [15:0] x_next;
  logic [15:0] y_next;

  assign tick = (div_cnt == DIV_LAST);

  // Direction decode. Codes 1..5 move right and 6..10 move left. The
  // vertical component is arranged symmetrically around codes 3 and 8.
  always_comb begin
    dir_valid = (direction >= 4'd1) && (direction <= 4'd10);
    dx_pos    = (direction >= 4'd1) && (direction <= 4'd5);
    v_up      = 1'b0;
    v_down    = 1'b0;
    v_full    = 1'b0;
    case (direction)
      4'd1:  begin v_up   = 1'b1; v_full = 1'b1; end
      4'd2:  begin v_up   = 1'b1; end
      4'd4:  begin v_down = 1'b1; end
      4'd5:  begin v_down = 1'b1; v_full = 1'b1; end
      4'd6:  begin v_down = 1'b1; v_full = 1'b1; end
      4'd7:  begin v_down = 1'b1; end
      4'd9:  begin v_up   = 1'b1; end
      4'd10: begin v_up   = 1'b1; v_full = 1'b1; end
      default: ;
    endcase
    // Half-rate directions step vertically only on odd phases.
    v_step = v_full | phase;
    x_cand = dx_pos ? ball_coord_horizontal + 16'd1 : ball_coord_horizontal - 16'd1;
    y_cand = v_up   ? ball_coord_vertical   - 16'd1 : ball_coord_vertical   + 16'd1;
    // Each axis saturates on its own. A blocked axis keeps its value and the
    // other axis still moves.
    x_next = ball_coord_horizontal;
    y_next = ball_coord_vertical;
    if (dir_valid && (x_cand >= H_MIN_C) && (x_cand <= H_MAX_C))
      x_next = x_cand;
    if ((v_up || v_down) && v_step && (y_cand >= V_MIN_C) && (y_cand <= V_MAX_C))
      y_next = y_cand;
  end

  always_ff @(posedge clk) begin
    if (reset_to_start) begin
      state                 <= SERVE;
      div_cnt               <= '0;
      serve_cnt             <= '0;
      phase                 <= 1'b0;
      ball_coord_horizontal <= START_H_C;
      ball_coord_vertical   <= START_V_C;
      move_tick             <= 1'b0;
      ball_active           <= 1'b0;
    end else begin
      // The divider free-runs in every state.
      div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);
      move_tick <= 1'b0;
      case (state)
        SERVE: begin
          if (stand) begin
            state       <= STOPPED;
            ball_active <= 1'b0;
          end else if (tick) begin
            serve_cnt <= serve_cnt + SERVE_W'(1);
            if (serve_cnt == SERVE_LAST) begin
              state       <= MOVING;
              ball_active <= 1'b1;
            end
          end
        end
        MOVING: begin
          // stand takes priority over a coincident tick, so no final step.
          if (stand) begin
            state       <= STOPPED;
            ball_active <= 1'b0;
          end else if (tick) begin
            ball_coord_horizontal <= x_next;
            ball_coord_vertical   <= y_next;
            phase                 <= ~phase;
            move_tick             <= 1'b1;
          end
        end
        STOPPED: begin
          ball_active <= 1'b0;
        end
        default: begin
          state       <= STOPPED;
          ball_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_generator.sv
module tb_ball_motion_generator;

  logic        clk = 1'b0;
  logic        reset_to_start = 1'b1;
  logic        stand = 1'b0;
  logic [3:0]  direction = 4'd3;
  logic [15:0] ball_coord_horizontal;
  logic [15:0] ball_coord_vertical;
  logic        move_tick;
  logic        ball_active;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  ball_motion_generator #(
    .MOVE_DIV    (4),
    .SERVE_TICKS (2)
  ) dut (
    .clk                   (clk),
    .reset_to_start        (reset_to_start),
    .stand                 (stand),
    .direction             (direction),
    .ball_coord_horizontal (ball_coord_horizontal),
    .ball_coord_vertical   (ball_coord_vertical),
    .move_tick             (move_tick),
    .ball_active           (ball_active)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_xy(input string tag, input int x, input int y);
    check_val({tag, "_x"}, 32'(ball_coord_horizontal), 32'(x));
    check_val({tag, "_y"}, 32'(ball_coord_vertical), 32'(y));
  endtask

  // Reset is held across one rising edge and sampled 1 time unit later.
  task automatic do_reset(input logic [3:0] dir);
    direction      = dir;
    stand          = 1'b0;
    reset_to_start = 1'b1;
    @(posedge clk); #1;
    reset_to_start = 1'b0;
    check_xy("rst", 462, 302);
    check_val("rst_move_tick", 32'(move_tick), 32'd0);
    check_val("rst_active", 32'(ball_active), 32'd0);
  endtask

  // Wait (bounded) for the next move_tick. Returns the number of edges taken.
  task automatic wait_move(output int edges);
    logic seen;
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (move_tick) seen = 1'b1;
    end
    check_val("move_seen", 32'(seen), 32'd1);
  endtask

  task automatic moves(input int n);
    int e;
    for (int i = 0; i < n; i++) wait_move(e);
  endtask

  initial begin
    int   e;
    logic held;
    logic act7;
    logic act8;

    // ---- reset, serve hold and direction 3 ----
    @(posedge clk); #1;
    do_reset(4'd3);
    held = 1'b1;
    act7 = 1'b0;
    act8 = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      if (ball_coord_horizontal != 16'd462 || ball_coord_vertical != 16'd302 || move_tick)
        held = 1'b0;
      if (i == 7) act7 = ball_active;
      if (i == 8) act8 = ball_active;
    end
    check_val("serve_hold", 32'(held), 32'd1);
    check_val("serve_active_e7", 32'(act7), 32'd0);
    check_val("serve_active_e8", 32'(act8), 32'd1);
    wait_move(e);
    check_val("first_move_edge", 32'(e), 32'd1);
    check_xy("d3_m1", 463, 302);
    wait_move(e);
    check_val("move_period", 32'(e), 32'd4);
    check_xy("d3_m2", 464, 302);
    @(posedge clk); #1;
    check_val("move_tick_pulse", 32'(move_tick), 32'd0);
    wait_move(e);
    check_xy("d3_m3", 465, 302);

    // ---- direction 1, full-rate up ----
    do_reset(4'd1);
    wait_move(e);
    check_val("d1_first_edge", 32'(e), 32'd12);
    check_xy("d1_m1", 463, 301);
    wait_move(e); check_xy("d1_m2", 464, 300);
    wait_move(e); check_xy("d1_m3", 465, 299);

    // ---- direction 2, half-rate up ----
    do_reset(4'd2);
    wait_move(e); check_xy("d2_m1", 463, 302);
    wait_move(e); check_xy("d2_m2", 464, 301);
    wait_move(e); check_xy("d2_m3", 465, 301);
    wait_move(e); check_xy("d2_m4", 466, 300);

    // ---- saturation at the borders ----
    direction = 4'd10;
    moves(135);
    check_xy("d10_reach_top", 331, 165);
    wait_move(e); check_xy("d10_sat_top", 330, 165);
    direction = 4'd3;
    moves(370);
    check_xy("d3_reach_right", 700, 165);
    wait_move(e); check_xy("d3_sat_right", 700, 165);
    direction = 4'd5;
    wait_move(e); check_xy("d5_at_right1", 700, 166);
    wait_move(e); check_xy("d5_at_right2", 700, 167);
    moves(273);
    check_xy("d5_reach_bottom", 700, 440);
    wait_move(e); check_xy("d5_sat_corner", 700, 440);
    direction = 4'd0;
    wait_move(e); check_xy("d0_hold", 700, 440);
    direction = 4'd8;
    wait_move(e); check_xy("d8_left", 699, 440);
    direction = 4'd6;
    wait_move(e); check_xy("d6_sat_bottom", 698, 440);
    direction = 4'd15;
    wait_move(e); check_xy("d15_hold", 698, 440);

    // ---- stand coincident with a tick at (500,300) ----
    do_reset(4'd3);
    moves(34);
    direction = 4'd1;
    moves(2);
    direction = 4'd3;
    moves(2);
    check_xy("reach_500_300", 500, 300);
    repeat (3) @(posedge clk);
    #1;
    stand = 1'b1;          // high during the tick cycle
    @(posedge clk); #1;
    check_val("stand_no_tick", 32'(move_tick), 32'd0);
    check_val("stand_inactive", 32'(ball_active), 32'd0);
    check_xy("stand_frozen", 500, 300);
    stand = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ball_coord_horizontal != 16'd500 || ball_coord_vertical != 16'd300 || move_tick || ball_active)
        held = 1'b0;
    end
    check_val("stopped_hold", 32'(held), 32'd1);

    // ---- reset from STOPPED, then resume ----
    do_reset(4'd3);
    wait_move(e);
    check_val("resume_edge", 32'(e), 32'd12);
    check_xy("resume_m1", 463, 302);

    // ---- reset mid-motion at (600,200), coincident with a tick ----
    direction = 4'd1;
    moves(102);
    direction = 4'd3;
    moves(35);
    check_xy("reach_600_200", 600, 200);
    repeat (3) @(posedge clk);
    #1;
    reset_to_start = 1'b1;
    @(posedge clk); #1;
    reset_to_start = 1'b0;
    check_xy("mid_rst", 462, 302);
    check_val("mid_rst_tick", 32'(move_tick), 32'd0);
    check_val("mid_rst_active", 32'(ball_active), 32'd0);
    wait_move(e);
    check_val("mid_rst_resume_edge", 32'(e), 32'd12);
    check_xy("mid_rst_m1", 463, 302);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
